// File: rtl/mct_arb.sv
// mct_arb: memory controller between the IF stage, the MEM stage and an 8-bit
// single-port RAM. Arbitrates the two requesters (MEM first), serialises
// 1/2/4-byte accesses into byte cycles and assembles little-endian read words.
// The last byte of a MEM load is not registered: the MEM stage takes it from
// ram_d_i in the mm_ok cycle.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   if_e/if_a           IF fetch request level and address
//   if_ok/if_n_o        one-cycle fetch-done pulse and fetched word
//   mm_e/mm_a/mm_wr     MEM request level, byte address, 1 = store
//   mm_cu/mm_n_i        size code (0:1B, 1:2B, 2/3:4B) and store data
//   mm_n_o/mm_ok        load bytes 0..N-2 and combinational done pulse
//   ram_a/ram_d_o/ram_wr  RAM address, write data, write strobe
//   ram_d_i             RAM read data, valid the cycle after its address
//
// Build option: define MCT_PREEMPT_EN to let a MEM request abort an
// in-flight IF fetch.

module mct_arb #(
    parameter int unsigned RAM_AW = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_e,
    input  logic [31:0]       if_a,
    output logic              if_ok,
    output logic [31:0]       if_n_o,
    input  logic              mm_e,
    input  logic [31:0]       mm_a,
    input  logic              mm_wr,
    input  logic [1:0]        mm_cu,
    input  logic [31:0]       mm_n_i,
    output logic [31:0]       mm_n_o,
    output logic              mm_ok,
    output logic [RAM_AW-1:0] ram_a,
    output logic [7:0]        ram_d_o,
    output logic              ram_wr,
    input  logic [7:0]        ram_d_i
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MM_RD   = 3'd1,
        MM_WR   = 3'd2,
        IF_RD   = 3'd3,
        IF_DONE = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [2:0]          cnt_q;
    logic [31:0]         base_q;
    logic [2:0]          n_q;
    logic [31:0]         wdata_q;
    logic [23:0]         if_buf_q;
    logic [31:0]         if_word_q;
    logic [31:0]         mm_word_q;
    logic [RAM_AW-1:0]   ram_a_q;

    logic [2:0]          mm_n_c;
    logic [31:0]         addr_full_c;
    logic [RAM_AW-1:0]   addr_c;
    logic [7:0]          wbyte_c;
    logic                preempt_c;
    logic                accept_mm_c;
    logic                accept_if_c;

    assign if_n_o = if_word_q;
    assign mm_n_o = mm_word_q;

    // Byte count of a MEM access; size code 2 is treated as a word.
    always_comb begin
        mm_n_c = 3'd4;
        case (mm_cu)
            2'd0:    mm_n_c = 3'd1;
            2'd1:    mm_n_c = 3'd2;
            default: mm_n_c = 3'd4;
        endcase
    end

    // Byte address, computed in 32 bits and wrapped to the RAM size.
    assign addr_full_c = base_q + 32'(cnt_q);
    assign addr_c      = addr_full_c[RAM_AW-1:0];

    always_comb begin
        wbyte_c = wdata_q[7:0];
        case (cnt_q[1:0])
            2'd0:    wbyte_c = wdata_q[7:0];
            2'd1:    wbyte_c = wdata_q[15:8];
            2'd2:    wbyte_c = wdata_q[23:16];
            default: wbyte_c = wdata_q[31:24];
        endcase
    end

`ifdef MCT_PREEMPT_EN
    assign preempt_c = (state_q == IF_RD) && mm_e;
`else
    assign preempt_c = 1'b0;
`endif

    assign accept_mm_c = ((state_q == IDLE) && mm_e) || preempt_c;
    assign accept_if_c = (state_q == IDLE) && !mm_e && if_e;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (mm_e)      state_d = mm_wr ? MM_WR : MM_RD;
                else if (if_e) state_d = IF_RD;
            end
            MM_RD:   if (cnt_q == n_q) state_d = IDLE;
            MM_WR:   if (cnt_q == n_q - 3'd1) state_d = IDLE;
            IF_RD: begin
                if (preempt_c)            state_d = mm_wr ? MM_WR : MM_RD;
                else if (!if_e)           state_d = IDLE;
                else if (cnt_q == 3'd4)   state_d = IF_DONE;
            end
            IF_DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode; ram_a holds its last value while idle.
    always_comb begin
        if_ok   = 1'b0;
        mm_ok   = 1'b0;
        ram_wr  = 1'b0;
        ram_d_o = 8'h00;
        ram_a   = ram_a_q;
        case (state_q)
            MM_RD: begin
                ram_a = addr_c;
                mm_ok = (cnt_q == n_q);
            end
            MM_WR: begin
                ram_a   = addr_c;
                ram_wr  = 1'b1;
                ram_d_o = wbyte_c;
                mm_ok   = (cnt_q == n_q - 3'd1);
            end
            IF_RD:   ram_a = addr_c;
            IF_DONE: if_ok = 1'b1;
            default: ;
        endcase
    end

    // Request latches, byte counter and read-data assembly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= 3'd0;
            base_q    <= 32'd0;
            n_q       <= 3'd0;
            wdata_q   <= 32'd0;
            if_buf_q  <= 24'd0;
            if_word_q <= 32'd0;
            mm_word_q <= 32'd0;
            ram_a_q   <= '0;
        end else begin
            ram_a_q <= ram_a;
            if (accept_mm_c || accept_if_c) begin
                cnt_q   <= 3'd0;
                base_q  <= accept_mm_c ? mm_a : if_a;
                n_q     <= accept_mm_c ? mm_n_c : 3'd4;
                wdata_q <= mm_n_i;
                if (accept_mm_c) mm_word_q <= 32'd0;
            end else if (state_q != IDLE) begin
                cnt_q <= cnt_q + 3'd1;
            end
            // Byte cnt-1 arrives while cnt is on the bus; the final byte is left to the consumer.
            if (state_q == MM_RD && cnt_q != n_q) begin
                for (int i = 0; i < 3; i++) begin
                    if (cnt_q == 3'(i + 1)) mm_word_q[8*i +: 8] <= ram_d_i;
                end
            end
            if (state_q == IF_RD) begin
                for (int i = 0; i < 3; i++) begin
                    if (cnt_q == 3'(i + 1)) if_buf_q[8*i +: 8] <= ram_d_i;
                end
                // Publish only on a completing fetch so an abort leaves if_n_o untouched.
                if (state_d == IF_DONE) if_word_q <= {ram_d_i, if_buf_q};
            end
        end
    end

endmodule
